// File: rtl/lgc_pkg.sv
// Shared definitions for the lock-gated counter: FSM state encodings and LED status patterns.
package lgc_pkg;

    // Lock qualifier states; encoding 2'd3 is unused and recovers to WAIT_LOCK.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lgc_state_e;

    // LED status patterns, truncated to the LED window width at the point of use.
    localparam logic [31:0] LED_PAT_OFF    = 32'd0;
    localparam logic [31:0] LED_PAT_SETTLE = 32'd1;

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises the PLL lock flag and qualifies it: RUN is entered only after the
// synchronised flag has stayed high for SETTLE_CYCLES consecutive cycles.
module lock_qualifier
    import lgc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       running,
    output lgc_state_e state
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic          lock_meta;
    logic          lock_s;
    logic [SW-1:0] settle_cnt;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Lock FSM; running is registered alongside the state so it tracks RUN exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            running    <= 1'b0;
        end else begin
            running <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else begin
                        running <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: rtl/lock_gated_counter.sv
// Modulo-N up/down counter that only counts once the PLL lock has settled,
// with a wrap pulse and a registered LED window of the count MSBs.
module lock_gated_counter
    import lgc_pkg::*;
#(
    parameter  int unsigned N             = 100_000_000,
    parameter  int unsigned SETTLE_CYCLES = 1024,
    parameter  int unsigned LED_W         = 8,
    localparam int unsigned WIDTH         = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             enable,
    input  logic             dir,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             running,
    output logic [LED_W-1:0] led
);

    // Reject parameter combinations the datapath cannot represent.
    if (N < 2) begin : g_bad_n
        $error("lock_gated_counter: N must be at least 2");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("lock_gated_counter: SETTLE_CYCLES must be at least 1");
    end
    if (LED_W > WIDTH) begin : g_bad_led
        $error("lock_gated_counter: LED_W must not exceed WIDTH");
    end

    localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(N - 1);

    lgc_state_e state;

    lock_qualifier #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_lock_qualifier (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .running    (running),
        .state      (state)
    );

    // Counter and wrap pulse: clear wins, then counting while running and enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (running && enable) begin
                if (!dir) begin
                    if (count == COUNT_LAST) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        count <= COUNT_LAST;
                        wrap  <= 1'b1;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
            end
        end
    end

    // LED register, one cycle behind count and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            case (state)
                RUN:     led <= count[WIDTH-1 -: LED_W];
                SETTLE:  led <= LED_W'(LED_PAT_SETTLE);
                default: led <= LED_W'(LED_PAT_OFF);
            endcase
        end
    end

endmodule

// File: tb/tb_lock_gated_counter.sv
// Self-checking bench for lock_gated_counter with N=10, SETTLE_CYCLES=4, LED_W=3.
module tb_lock_gated_counter;

    localparam int unsigned N             = 10;
    localparam int unsigned SETTLE_CYCLES = 4;
    localparam int unsigned LED_W         = 3;
    localparam int unsigned WIDTH         = 4;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             wrap;
        logic             running;
        logic [LED_W-1:0] led;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             pll_locked;
    logic             enable;
    logic             dir;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             running;
    logic [LED_W-1:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    // Reference model: lock history as a streak of synchronised-high samples.
    int m_streak;
    int m_count;
    int m_led;
    bit m_wrap;
    bit m_l1;
    bit m_l2;

    lock_gated_counter #(
        .N             (N),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LED_W         (LED_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .enable     (enable),
        .dir        (dir),
        .clear      (clear),
        .count      (count),
        .wrap       (wrap),
        .running    (running),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_count  = 0;
        m_led    = 0;
        m_wrap   = 1'b0;
        m_l1     = 1'b0;
        m_l2     = 1'b0;
        sb_q.delete();
    endtask

    // Predict the next edge, push it, advance one clock and compare.
    task automatic step();
        exp_t e;
        bit   run_pre;
        run_pre = (m_streak >= int'(SETTLE_CYCLES) + 1);
        if (run_pre)           m_led = m_count >> (WIDTH - LED_W);
        else if (m_streak > 0) m_led = 1;
        else                   m_led = 0;
        if (clear) begin
            m_count = 0;
            m_wrap  = 1'b0;
        end else if (run_pre && enable) begin
            m_wrap  = dir ? (m_count == 0) : (m_count == int'(N) - 1);
            m_count = dir ? (m_count + int'(N) - 1) % int'(N) : (m_count + 1) % int'(N);
        end else begin
            m_wrap = 1'b0;
        end
        m_streak = m_l2 ? ((m_streak < 1000) ? m_streak + 1 : m_streak) : 0;
        m_l2 = m_l1;
        m_l1 = pll_locked;
        e.count   = WIDTH'(m_count);
        e.wrap    = m_wrap;
        e.running = (m_streak >= int'(SETTLE_CYCLES) + 1);
        e.led     = LED_W'(m_led);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_count",   32'(count),   32'(e.count));
        check("sb_wrap",    32'(wrap),    32'(e.wrap));
        check("sb_running", 32'(running), 32'(e.running));
        check("sb_led",     32'(led),     32'(e.led));
    endtask

    task automatic run_until_count(input int target, input int budget);
        for (int i = 0; i < budget && int'(count) != target; i++) step();
        check("reach_count", 32'(count), 32'(target));
    endtask

    task automatic measure_lock(input string tag);
        int lat;
        lat = 0;
        while (running !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check(tag, 32'(lat), 32'(3 + SETTLE_CYCLES));
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        enable     = 1'b0;
        dir        = 1'b0;
        clear      = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_count",   32'(count),   32'd0);
        check("rst_wrap",    32'(wrap),    32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_led",     32'(led),     32'd0);
        rst = 1'b0;

        // Lock glitch during SETTLE: three cycles high, one low, then held high.
        enable     = 1'b1;
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pll_locked = 1'b0;
        step();
        check("glitch_running", 32'(running), 32'd0);
        pll_locked = 1'b1;
        measure_lock("relock_latency");
        check("run_first_count", 32'(count), 32'd0);
        check("run_first_led",   32'(led),   32'd1);
        step();
        check("run_count_1", 32'(count), 32'd1);

        // Up wrap 9 -> 0, then down through 0 -> 9.
        run_until_count(9, 20);
        step();
        check("up_wrap_count", 32'(count), 32'd0);
        check("up_wrap_pulse", 32'(wrap),  32'd1);
        check("led_of_9",      32'(led),   32'b100);
        step();
        check("up_wrap_drop", 32'(wrap), 32'd0);
        dir = 1'b1;
        step();
        check("dn_to_0", 32'(count), 32'd0);
        check("dn_no_wrap", 32'(wrap), 32'd0);
        step();
        check("dn_wrap_count", 32'(count), 32'd9);
        check("dn_wrap_pulse", 32'(wrap),  32'd1);
        step();
        check("dn_wrap_drop", 32'(wrap), 32'd0);

        // Clear beats enable at count 9.
        dir = 1'b0;
        run_until_count(9, 20);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", 32'(count), 32'd0);
        check("clear_wrap",  32'(wrap),  32'd0);

        // LED window of count 6.
        run_until_count(6, 20);
        step();
        check("led_of_6", 32'(led), 32'b011);

        // Lock loss at count 5 freezes the count; relock resumes from it.
        run_until_count(5, 20);
        enable     = 1'b0;
        pll_locked = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("hold_count",   32'(count),   32'd5);
        check("hold_running", 32'(running), 32'd0);
        check("hold_led",     32'(led),     32'd0);
        enable     = 1'b1;
        pll_locked = 1'b1;
        measure_lock("resume_latency");
        check("resume_held", 32'(count), 32'd5);
        step();
        check("resume_next", 32'(count), 32'd6);

        // Asynchronous reset mid-count takes effect without a clock edge.
        run_until_count(6, 20);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count",   32'(count),   32'd0);
        check("async_rst_wrap",    32'(wrap),    32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_led",     32'(led),     32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Fresh lock after reset: full latency, then counting from 0.
        measure_lock("fresh_latency");
        check("fresh_count_0", 32'(count), 32'd0);
        step();
        step();
        check("fresh_count_2", 32'(count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
